branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of pc, imm and target.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 0-7, number of cycles flush is held after a taken branch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  branch request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port funct3  input  3  RV32I branch funct3.
REQ-008 SHALL have ports pc, imm  input  XLEN each  branch PC and sign-extended B-immediate.
REQ-009 SHALL have ports N, Z, C, V  input  1 each  adder flags from the X-Y subtract of rs1/rs2 (N = signed rs1<rs2, C = carry out, 1 when rs1>=rs2 unsigned).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  result consumer ready.
REQ-012 SHALL have ports taken, illegal, misaligned  output  1 each  result qualifiers.
REQ-013 SHALL have port target  output  XLEN  pc+imm.
REQ-014 SHALL have port flush  output  1  pipeline flush request.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL, RESP, FLUSH.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready latches funct3, pc, imm, N, Z, C, V and moves IDLE->EVAL.
REQ-017 EVAL SHALL compute target = pc+imm modulo 2^XLEN and taken, then move to RESP; out_valid SHALL rise two cycles after the accept edge.
REQ-018 Conditions: 000 BEQ=Z; 001 BNE=!Z; 100 BLT=N; 101 BGE=!N; 110 BLTU=!C; 111 BGEU=C; V SHALL be ignored.
REQ-019 funct3 010/011 SHALL give illegal=1, taken=0.
REQ-020 misaligned SHALL be 1 when taken=1 and target[1:0]!=2'b00.
REQ-021 In RESP out_valid and result outputs SHALL be held stable until out_ready=1; handshake in the first RESP cycle SHALL complete.
REQ-022 On RESP handshake: taken=1, misaligned=0, FLUSH_CYCLES>0 -> FLUSH; otherwise -> IDLE.
REQ-023 flush SHALL be 1 exactly FLUSH_CYCLES consecutive cycles in FLUSH, then IDLE.
REQ-024 in_valid outside IDLE SHALL be ignored and no input SHALL be sampled.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and in_ready=1, out_valid=0, taken=0, illegal=0, misaligned=0, flush=0, target=0, at any state including mid-FLUSH.
REQ-026 The first request SHALL be accepted no earlier than the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro BRANCH_UNIT_STATS_EN defined SHALL add outputs taken_cnt and not_taken_cnt (32 bits each), incremented on each RESP handshake with illegal=0, saturating at 0xFFFFFFFF, reset to 0.
REQ-028 Without BRANCH_UNIT_STATS_EN those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the funct3 constants (BEQ..BGEU) and the FSM state typedef.
REQ-030 Condition decode (funct3, N, Z, C -> taken, illegal) SHALL be a combinational sub-module branch_cond.

Verification
REQ-031 BEQ, Z=1, pc=0x100, imm=0x20, out_ready=1 -> out_valid 2 cycles after accept, taken=1, target=0x120, flush 2 cycles, in_ready again after that.
REQ-032 BLTU, C=1 -> taken=0, no flush, in_ready=1 the cycle after handshake; BGEU, C=1 -> taken=1.
REQ-033 funct3=010 -> illegal=1, taken=0, no flush; pc=0x100, imm=0x6, BNE, Z=0 -> taken=1, misaligned=1, no flush.
REQ-034 out_ready low 5 cycles in RESP while in_valid toggles -> outputs stable, no second accept.
REQ-035 pc=0xFFFFFFF0, imm=0x20 -> target=0x10; rst_n low mid-FLUSH -> flush=0 and IDLE immediately.
REQ-036 With BRANCH_UNIT_STATS_EN: 3 taken, 2 not-taken, 1 illegal -> taken_cnt=3, not_taken_cnt=2.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared constants for the branch unit: RV32I branch funct3 encodings and
// the FSM state type used by branch_unit.
package branch_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_EVAL  = 2'd1;
    localparam state_t ST_RESP  = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational branch condition decode. Flags come from the rs1-rs2
// subtract: n = signed less-than, z = equal, c = carry (unsigned rs1>=rs2).
// The overflow flag is not needed because n is already the signed compare.
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    output logic       taken,
    output logic       illegal
);

    // Map funct3 onto the selected flag; reserved encodings flag illegal.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = z;
            F3_BNE:  taken = ~z;
            F3_BLT:  taken = n;
            F3_BGE:  taken = ~n;
            F3_BLTU: taken = ~c;
            F3_BGEU: taken = c;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: accepts one request, evaluates the condition and
// target, presents the result until consumed, then optionally holds a
// pipeline flush for FLUSH_CYCLES cycles after a correctly aligned taken
// branch. Optional macro BRANCH_UNIT_STATS_EN adds saturating taken /
// not-taken counters.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// EVAL  | compute target and condition from latched operands
// RESP  | result valid, held until out_ready
// FLUSH | flush asserted, down-counter running
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            illegal,
    output logic            misaligned,
    output logic [XLEN-1:0] target,
    output logic            flush
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     not_taken_cnt
`endif
);

    localparam logic       FLUSH_EN   = (FLUSH_CYCLES > 0);
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    state_t          state, state_nxt;
    logic [2:0]      flush_cnt;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q, imm_q;
    logic            n_q, z_q, c_q;
    logic            cond_taken, cond_illegal;
    logic [XLEN-1:0] sum;
    logic            accept, resp_hs, go_flush;
    logic            unused_v;

    // V is redundant with N for signed compares.
    assign unused_v = V;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_RESP);
    assign flush     = (state == ST_FLUSH);
    assign accept    = in_valid & in_ready;
    assign resp_hs   = out_valid & out_ready;
    assign go_flush  = FLUSH_EN & taken & ~misaligned;
    assign sum       = pc_q + imm_q;

    branch_cond u_cond (
        .funct3  (funct3_q),
        .n       (n_q),
        .z       (z_q),
        .c       (c_q),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_EVAL;
            ST_EVAL:  state_nxt = ST_RESP;
            ST_RESP:  if (out_ready) state_nxt = go_flush ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (flush_cnt == 3'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (resp_hs)
                flush_cnt <= FLUSH_LOAD;
            else if (state == ST_FLUSH && flush_cnt != 3'd0)
                flush_cnt <= flush_cnt - 3'd1;
        end
    end

    // Operand capture only on accept, so requests outside IDLE are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= 3'd0;
            pc_q     <= '0;
            imm_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else if (accept) begin
            funct3_q <= funct3;
            pc_q     <= pc;
            imm_q    <= imm;
            n_q      <= N;
            z_q      <= Z;
            c_q      <= C;
        end
    end

    // Result registers, written in EVAL and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target     <= '0;
            taken      <= 1'b0;
            illegal    <= 1'b0;
            misaligned <= 1'b0;
        end else if (state == ST_EVAL) begin
            target     <= sum;
            taken      <= cond_taken;
            illegal    <= cond_illegal;
            misaligned <= cond_taken & (sum[1:0] != 2'b00);
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    // Saturating outcome counters, bumped once per consumed legal result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt     <= 32'd0;
            not_taken_cnt <= 32'd0;
        end else if (resp_hs && !illegal) begin
            if (taken && taken_cnt != 32'hFFFF_FFFF)
                taken_cnt <= taken_cnt + 32'd1;
            else if (!taken && not_taken_cnt != 32'hFFFF_FFFF)
                not_taken_cnt <= not_taken_cnt + 32'd1;
        end
    end
`endif

endmodule
